// File: rtl/gen1_boot_ram_loader_pkg.sv
// Shared types and helpers for the boot RAM loader: FSM states, RAM geometry, lane masks.
package gen1_boot_pkg;

  localparam int BOOT_WORDS  = 512;
  localparam int BOOT_ADDR_W = 9;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FILL   = 3'd1,
    WRITE  = 3'd2,
    FINISH = 3'd3,
    VERIFY = 3'd4,
    DONE   = 3'd5
  } boot_state_t;

  // Byte count (1..4) of a word to its Avalon byteenable.
  function automatic logic [3:0] lane_mask(input logic [2:0] nbytes);
    case (nbytes)
      3'd1:    return 4'b0001;
      3'd2:    return 4'b0011;
      3'd3:    return 4'b0111;
      3'd4:    return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] lane_bits(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/gen1_boot_ram_loader_if.sv
// Host byte stream plus Avalon-MM boot RAM port; master = loader side, slave = host/RAM side.
interface gen1_boot_ram_loader_if #(
  parameter int ADDR_W = 9
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_eop;
  logic              in_ready;
  logic [ADDR_W-1:0] m_address;
  logic              m_chipselect;
  logic              m_write;
  logic              m_read;
  logic [3:0]        m_byteenable;
  logic [31:0]       m_writedata;
  logic [31:0]       m_readdata;

  modport master (
    input  in_data, in_valid, in_eop, m_readdata,
    output in_ready, m_address, m_chipselect, m_write, m_read, m_byteenable, m_writedata
  );

  modport slave (
    output in_data, in_valid, in_eop, m_readdata,
    input  in_ready, m_address, m_chipselect, m_write, m_read, m_byteenable, m_writedata
  );
endinterface

// File: rtl/gen1_boot_ram_loader_byte_packer.sv
// Little-endian byte-to-word packer; presents the merged word and its lane mask on the completing byte.
module gen1_boot_byte_packer
  import gen1_boot_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  data,
  input  logic        eop,
  output logic [31:0] word_next,
  output logic [3:0]  be_next,
  output logic        complete
);

  logic [1:0]  lane;
  logic [31:0] word;

  // Merge the incoming byte into its lane; unfilled lanes stay zero.
  always_comb begin
    word_next = word;
    case (lane)
      2'd0:    word_next[7:0]   = data;
      2'd1:    word_next[15:8]  = data;
      2'd2:    word_next[23:16] = data;
      default: word_next[31:24] = data;
    endcase
  end

  assign be_next  = lane_mask({1'b0, lane} + 3'd1);
  assign complete = accept & ((lane == 2'd3) | eop);

  // Completed words are captured by the parent, so the packer restarts empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (clear || complete) begin
      lane <= 2'd0;
      word <= 32'd0;
    end else if (accept) begin
      lane <= lane + 2'd1;
      word <= word_next;
    end else begin
      lane <= lane;
      word <= word;
    end
  end

endmodule

// File: rtl/gen1_boot_ram_loader.sv
// Streams host bytes into the boot RAM as packed words with a running checksum.
// Optional readback verify pass enabled by defining GEN1_BOOT_LOADER_VERIFY_EN.
module gen1_boot_ram_loader
  import gen1_boot_pkg::*;
#(
  parameter int ADDR_W    = BOOT_ADDR_W,
  parameter int MAX_WORDS = BOOT_WORDS
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  gen1_boot_ram_loader_if.master bus,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic                   verify_err,
  output logic [ADDR_W:0]        word_count,
  output logic [31:0]            checksum
);

  localparam logic [ADDR_W:0] WC_MAX = (ADDR_W + 1)'(MAX_WORDS);
  localparam logic [ADDR_W:0] WC_ONE = {{ADDR_W{1'b0}}, 1'b1};

  boot_state_t state;
  logic        eop_seen;
  logic        accept;
  logic        full;
  logic        start_ok;
  logic [31:0] pk_word;
  logic [3:0]  pk_be;
  logic        pk_complete;

  assign accept   = bus.in_valid & bus.in_ready;
  assign full     = (word_count == WC_MAX);
  assign start_ok = start & ((state == IDLE) | (state == DONE));

  gen1_boot_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (start_ok),
    .accept    (accept & ~full),
    .data      (bus.in_data),
    .eop       (bus.in_eop),
    .word_next (pk_word),
    .be_next   (pk_be),
    .complete  (pk_complete)
  );

`ifdef GEN1_BOOT_LOADER_VERIFY_EN
  logic [ADDR_W:0] rd_cnt;
  logic [ADDR_W:0] ret_cnt;
  logic            rd_vld;
  logic [31:0]     vsum;
  logic [3:0]      last_be;
`else
  logic unused_readdata;
  assign unused_readdata = ^bus.m_readdata;
  assign bus.m_read      = 1'b0;
  assign verify_err      = 1'b0;
`endif

  // Loader FSM with every bus and status output registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      bus.in_ready     <= 1'b0;
      bus.m_address    <= '0;
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_byteenable <= 4'h0;
      bus.m_writedata  <= 32'h0;
      busy             <= 1'b0;
      done             <= 1'b0;
      overflow         <= 1'b0;
      word_count       <= '0;
      checksum         <= 32'h0;
      eop_seen         <= 1'b0;
`ifdef GEN1_BOOT_LOADER_VERIFY_EN
      bus.m_read       <= 1'b0;
      verify_err       <= 1'b0;
      rd_cnt           <= '0;
      ret_cnt          <= '0;
      rd_vld           <= 1'b0;
      vsum             <= 32'h0;
      last_be          <= 4'h0;
`endif
    end else begin
      bus.m_chipselect <= 1'b0;
      bus.m_write      <= 1'b0;
      bus.m_byteenable <= 4'h0;
`ifdef GEN1_BOOT_LOADER_VERIFY_EN
      bus.m_read       <= 1'b0;
      rd_vld           <= bus.m_read;
`endif
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state        <= FILL;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            done         <= 1'b0;
            overflow     <= 1'b0;
            word_count   <= '0;
            checksum     <= 32'h0;
            eop_seen     <= 1'b0;
`ifdef GEN1_BOOT_LOADER_VERIFY_EN
            verify_err   <= 1'b0;
`endif
          end else begin
            state <= state;
          end
        end
        FILL: begin
          // Once the RAM is full, bytes are swallowed until eop closes the image.
          if (accept && full) begin
            overflow <= 1'b1;
            if (bus.in_eop) begin
              state        <= FINISH;
              bus.in_ready <= 1'b0;
            end else begin
              state <= FILL;
            end
          end else if (pk_complete) begin
            state            <= WRITE;
            bus.in_ready     <= 1'b0;
            bus.m_chipselect <= 1'b1;
            bus.m_write      <= 1'b1;
            bus.m_address    <= word_count[ADDR_W-1:0];
            bus.m_byteenable <= pk_be;
            bus.m_writedata  <= pk_word;
            eop_seen         <= bus.in_eop;
`ifdef GEN1_BOOT_LOADER_VERIFY_EN
            last_be          <= pk_be;
`endif
          end else begin
            state <= FILL;
          end
        end
        WRITE: begin
          word_count <= word_count + WC_ONE;
          checksum   <= checksum + bus.m_writedata;
          if (eop_seen) begin
            state <= FINISH;
          end else begin
            state        <= FILL;
            bus.in_ready <= 1'b1;
          end
        end
        FINISH: begin
`ifdef GEN1_BOOT_LOADER_VERIFY_EN
          rd_cnt  <= '0;
          ret_cnt <= '0;
          vsum    <= 32'h0;
          if (word_count != '0) begin
            state <= VERIFY;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
`else
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
`endif
        end
        VERIFY: begin
`ifdef GEN1_BOOT_LOADER_VERIFY_EN
          // Reads issue one per cycle; returns are summed one cycle behind.
          if (rd_cnt < word_count) begin
            bus.m_read       <= 1'b1;
            bus.m_chipselect <= 1'b1;
            bus.m_byteenable <= 4'hF;
            bus.m_address    <= rd_cnt[ADDR_W-1:0];
            rd_cnt           <= rd_cnt + WC_ONE;
          end else begin
            rd_cnt <= rd_cnt;
          end
          if (rd_vld) begin
            vsum    <= vsum + (bus.m_readdata &
                       ((ret_cnt == word_count - WC_ONE) ? lane_bits(last_be) : 32'hFFFF_FFFF));
            ret_cnt <= ret_cnt + WC_ONE;
            state   <= VERIFY;
          end else if (ret_cnt == word_count) begin
            verify_err <= (vsum != checksum);
            state      <= DONE;
            busy       <= 1'b0;
            done       <= 1'b1;
          end else begin
            state <= VERIFY;
          end
`else
          state <= IDLE;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
